alu_issue_sched: RTL

- Shares one fixed-latency floating-point ALU (pipelined Add, latency ADD_LAT; pipelined Mul, latency MUL_LAT; output select by `op` at result time) between NREQ requesters.
- Per cycle:
  - Arbitrates round-robin among valid requests.
  - Drives operands into the ALU.
  - Reserves the result slot so add/mul completions never collide.
  - Drives the ALU `op` select on the completion cycle.
  - Returns tagged results.
- Sits between request ports (valid/ready) and the shared ALU instance.

---
 rtl/alu_sched_pkg.sv | 26 ++
 rtl/alu_issue_sched_if.sv | 36 +++
 rtl/alu_sched_rr_arb.sv | 42 ++++
 rtl/alu_issue_sched.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and defaults for the ALU issue scheduler.
// Reservation entries record who owns each future ALU completion slot.
package alu_sched_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } alu_op_t;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NREQ    = 2;
  localparam int DEF_ADD_LAT = 2;
  localparam int DEF_MUL_LAT = 3;
  localparam int ID_W_MAX    = 3;

  typedef struct packed {
    logic                busy;
    logic [ID_W_MAX-1:0] id;
    alu_op_t             op;
  } res_entry_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_issue_sched_if.sv
// Requester, shared-ALU and response signals of the issue scheduler.
// master = requesters + ALU instance side, slave = scheduler side.
interface alu_issue_sched_if
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
);
  localparam int IDW = id_w(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_op;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic                  alu_op;
  logic [WIDTH-1:0]      alu_result;
  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic                  resp_op;
  logic [WIDTH-1:0]      resp_data;
  logic                  idle;

  modport master (
    output req_valid, req_op, req_a, req_b, alu_result,
    input  req_ready, alu_a, alu_b, alu_op, resp_valid, resp_id, resp_op, resp_data, idle
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result,
    output req_ready, alu_a, alu_b, alu_op, resp_valid, resp_id, resp_op, resp_data, idle
  );

endinterface

// File: rtl/alu_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant among eligible requesters, combinational.
// Search starts at the pointer; pointer moves to grant+1 only when a grant is made.
module alu_sched_rr_arb #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] i_elig,
  output logic [NREQ-1:0] o_grant
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nx;
  logic [PW-1:0] w_idx;
  logic [PW:0]   w_sum;
  logic          w_found;

  always_comb begin
    o_grant  = '0;
    w_ptr_nx = r_ptr;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
      w_idx = w_sum[PW-1:0];
      if (!w_found && i_elig[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        w_ptr_nx       = (w_idx == PW'(NREQ-1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_ptr <= '0;
    else        r_ptr <= w_ptr_nx;
  end

endmodule

// File: rtl/alu_issue_sched.sv
// Shares one add/mul ALU among NREQ requesters; handshake-to-response latency L(op)+2.
// A request stalls (ready=0) while its completion slot is reserved; optional ALU_SCHED_STATS_EN adds counters.
module alu_issue_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREQ    = DEF_NREQ,
  parameter int ADD_LAT = DEF_ADD_LAT,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input logic clk,
  input logic reset,
  alu_issue_sched_if.slave bus
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_stalls
`endif
);
  localparam int LMAX = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int IDW  = id_w(NREQ);

  res_entry_t r_res    [1:LMAX];
  res_entry_t w_res_nx [1:LMAX];
  res_entry_t w_new;

  logic [WIDTH-1:0] r_alu_a, r_alu_b, r_resp_data;
  logic             r_cmp_vld, r_cmp_op, r_resp_vld, r_resp_op;
  logic [IDW-1:0]   r_cmp_id, r_resp_id;

  logic [NREQ-1:0]     w_elig, w_grant;
  logic                w_gnt_any, w_gnt_op, w_add_free, w_mul_free, w_any_busy;
  logic [ID_W_MAX-1:0] w_gnt_idx;
  logic [WIDTH-1:0]    w_gnt_a, w_gnt_b;

  // A slot is free after the shift if nothing sits one stage above it.
  generate
    if (ADD_LAT == LMAX) begin : g_add_top
      assign w_add_free = 1'b1;
    end else begin : g_add_chk
      assign w_add_free = !r_res[ADD_LAT+1].busy;
    end
    if (MUL_LAT == LMAX) begin : g_mul_top
      assign w_mul_free = 1'b1;
    end else begin : g_mul_chk
      assign w_mul_free = !r_res[MUL_LAT+1].busy;
    end
  endgenerate

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++)
      w_elig[i] = bus.req_valid[i] && (bus.req_op[i] ? w_mul_free : w_add_free);
  end

  alu_sched_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_elig  (w_elig),
    .o_grant (w_grant)
  );

  assign bus.req_ready = w_grant;

  always_comb begin
    w_gnt_any = |w_grant;
    w_gnt_idx = '0;
    w_gnt_op  = 1'b0;
    w_gnt_a   = '0;
    w_gnt_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_gnt_idx = ID_W_MAX'(i);
        w_gnt_op  = bus.req_op[i];
        w_gnt_a   = bus.req_a[i*WIDTH +: WIDTH];
        w_gnt_b   = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_new.busy = w_gnt_any;
    w_new.id   = w_gnt_idx;
    w_new.op   = alu_op_t'(w_gnt_op);
    for (int k = 1; k < LMAX; k++) w_res_nx[k] = r_res[k+1];
    w_res_nx[LMAX] = '0;
    if (w_gnt_any) begin
      if (w_gnt_op) w_res_nx[MUL_LAT] = w_new;
      else          w_res_nx[ADD_LAT] = w_new;
    end
  end

  always_comb begin
    w_any_busy = 1'b0;
    for (int k = 1; k <= LMAX; k++) w_any_busy = w_any_busy | r_res[k].busy;
  end

  // r_cmp_* marks the cycle the ALU result is on alu_result; it drives alu_op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 1; k <= LMAX; k++) r_res[k] <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_cmp_vld   <= 1'b0;
      r_cmp_op    <= 1'b0;
      r_cmp_id    <= '0;
      r_resp_vld  <= 1'b0;
      r_resp_op   <= 1'b0;
      r_resp_id   <= '0;
      r_resp_data <= '0;
    end else begin
      r_res     <= w_res_nx;
      r_cmp_vld <= r_res[1].busy;
      r_cmp_op  <= r_res[1].busy && (r_res[1].op == OP_MUL);
      r_cmp_id  <= IDW'(r_res[1].id);
      if (w_gnt_any) begin
        r_alu_a <= w_gnt_a;
        r_alu_b <= w_gnt_b;
      end
      r_resp_vld <= r_cmp_vld;
      if (r_cmp_vld) begin
        r_resp_op   <= r_cmp_op;
        r_resp_id   <= r_cmp_id;
        r_resp_data <= bus.alu_result;
      end
    end
  end

  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_op     = r_cmp_op;
  assign bus.resp_valid = r_resp_vld;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_op    = r_resp_op;
  assign bus.resp_data  = r_resp_data;
  assign bus.idle       = !w_any_busy && !r_cmp_vld && !r_resp_vld;

`ifdef ALU_SCHED_STATS_EN
  logic [31:0] r_stat_issued, r_stat_stalls;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stat_issued <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (w_gnt_any) r_stat_issued <= r_stat_issued + 32'd1;
      if (|bus.req_valid && !w_gnt_any) r_stat_stalls <= r_stat_stalls + 32'd1;
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_stalls = r_stat_stalls;
`endif

endmodule
